fft_frame_packer: RTL and testbench
===================================

FFT_FRAME_PACKER -- requirements
Module: fft_frame_packer

Interface
REQ-001 Parameter DATA_W, default 14, bit width of each real/imag sample component.
REQ-002 Parameter CH_W, default 2, width of the channel tag.
REQ-003 Parameter LEN_LOG2_MAX, default 10, log2 of the largest frame length (1024 points).
REQ-004 Parameter FIFO_DEPTH, default 16, output FIFO entries; power of 2, at least 2.
REQ-005 Port clk_clk, input, 1, single clock; all logic is rising-edge.
REQ-006 Port reset_reset, input, 1, asynchronous active-high reset.
REQ-007 Port in_valid / in_ready, input / output, 1 / 1, sample handshake; a beat is accepted when both are high.
REQ-008 Port in_real / in_imag, input, DATA_W each, sample components.
REQ-009 Port in_channel, input, CH_W, channel tag of the sample.
REQ-010 Port in_flush, input, 1, pulse that requests zero-padding of the current partial frame.
REQ-011 Port cfg_len_log2, input, $clog2(LEN_LOG2_MAX+1), frame length select; the frame length is 2^cfg_len_log2.
REQ-012 Port cfg_inverse, input, 1, transform-direction flag for the next frame.
REQ-013 Port out_valid / out_ready, output / input, 1 / 1, Avalon-ST source handshake toward the FFT sink.
REQ-014 Port out_data, output, 2*DATA_W+1, {inverse, imag, real}.
REQ-015 Port out_sop / out_eop, output, 1 each, first and last beat of a frame.
REQ-016 Port out_channel, output, CH_W, channel tag of the beat.
REQ-017 Port out_error, output, 2, error bits: [0] channel mismatch, [1] padded beat.

Function
REQ-018 Block SHALL run FSM states IDLE, FILL, PAD; IDLE means no partial frame is in progress.
REQ-019 On a beat accepted in IDLE, the block SHALL latch the frame length (cfg_len_log2, clamped to LEN_LOG2_MAX), cfg_inverse and in_channel, set sop on that beat, and go to FILL.
REQ-020 Each accepted beat (and each pad beat) SHALL increment the beat counter; the beat with count == length-1 SHALL carry eop, reset the counter to 0 and return to IDLE.
REQ-021 When the length is 1 (cfg_len_log2 = 0), every beat SHALL carry both sop and eop.
REQ-022 In FILL, a beat whose in_channel differs from the latched channel SHALL be accepted with out_error[0]=1 and out_channel set to the latched channel.
REQ-023 On in_flush in FILL, the block SHALL enter PAD after any beat accepted in the same cycle, unless that beat was the eop beat, in which case it SHALL return to IDLE.
REQ-024 In PAD, in_ready SHALL be 0 and the block SHALL push one zero-data beat per cycle while the FIFO is not full, with out_error[1]=1 and the latched inverse bit and channel, until eop, then go to IDLE.
REQ-025 in_flush SHALL be ignored in IDLE and in PAD.
REQ-026 in_ready SHALL equal (state != PAD) and (FIFO not full); it SHALL be registered-free of out_ready, with no combinational path from out_ready.
REQ-027 FIFO SHALL hold {data, sop, eop, channel, error}; push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-028 Latency SHALL be 1 cycle from an accepted in-beat to out_valid when the FIFO is empty.
REQ-029 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 cfg_len_log2 and cfg_inverse changes mid-frame SHALL NOT affect the current frame.

Reset
REQ-031 Reset SHALL asynchronously clear the FIFO, counter and FSM (to IDLE).
REQ-032 During reset, out_valid, out_sop, out_eop, out_error and in_ready SHALL all be 0, and out_data and out_channel SHALL be 0.
REQ-033 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-034 Reset mid-frame SHALL discard the partial frame; the next accepted beat SHALL carry sop.

Verification
REQ-035 Basic frame: len_log2=2, inverse=1, 4 beats on ch1, out_ready=1 -> 4 out beats with data MSB=1, sop on beat 0 and eop on beat 3, error=0, each beat 1 cycle after its input.
REQ-036 Flush/pad: len_log2=3, 3 beats, then in_flush -> 5 zero beats with error[1]=1, eop on the 8th beat, and in_ready=0 during pad.
REQ-037 Backpressure: FIFO_DEPTH=16, out_ready=0, stream 20 beats -> exactly 16 accepted and in_ready=0; release out_ready -> order preserved with no loss.
REQ-038 Channel mismatch: frame latched on ch0, beat 2 tagged ch3 -> that beat has error[0]=1 and out_channel=0.
REQ-039 Edge cases: len_log2=0 gives sop=eop=1 on every beat; len_log2 above LEN_LOG2_MAX is clamped; reset mid-frame followed by new beats gives sop on the first.

Source files
------------

// File: rtl/fft_frame_packer.sv
// rtl/fft_frame_packer.sv - packs streamed complex samples into power-of-two FFT frames
// with zero-padding on flush, channel-mismatch tagging and an output FIFO toward the FFT sink.
module fft_frame_packer #(
  parameter int DATA_W       = 14,
  parameter int CH_W         = 2,
  parameter int LEN_LOG2_MAX = 10,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                clk_clk,
  input  logic                                reset_reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_real,
  input  logic [DATA_W-1:0]                   in_imag,
  input  logic [CH_W-1:0]                     in_channel,
  input  logic                                in_flush,
  input  logic [$clog2(LEN_LOG2_MAX+1)-1:0]   cfg_len_log2,
  input  logic                                cfg_inverse,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*DATA_W:0]                   out_data,
  output logic                                out_sop,
  output logic                                out_eop,
  output logic [CH_W-1:0]                     out_channel,
  output logic [1:0]                          out_error
);

  localparam int SEL_W = $clog2(LEN_LOG2_MAX + 1);
  localparam int CNT_W = (LEN_LOG2_MAX > 0) ? LEN_LOG2_MAX : 1;
  localparam int OD_W  = 2 * DATA_W + 1;
  localparam int ENT_W = OD_W + 2 + CH_W + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, PAD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   len_q, len_sel, cfg_len_clamped;
  logic               inv_q;
  logic [CH_W-1:0]    ch_q;
  logic               rst_done;

  logic [CNT_W:0]     len_pow, last_full;
  logic               at_last;
  logic               accept, pad_push, push, pop;

  logic               push_sop, push_inv;
  logic [CH_W-1:0]    push_ch;
  logic [1:0]         push_err;
  logic [DATA_W-1:0]  push_re, push_im;
  logic [ENT_W-1:0]   push_entry, head;

  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               fifo_full, fifo_empty;

  // Length is taken live from cfg only on the first beat; afterwards the latched value rules.
  assign cfg_len_clamped = (cfg_len_log2 > SEL_W'(LEN_LOG2_MAX)) ? SEL_W'(LEN_LOG2_MAX) : cfg_len_log2;
  assign len_sel   = (state == IDLE) ? cfg_len_clamped : len_q;
  assign len_pow   = (CNT_W+1)'(1) << len_sel;
  assign last_full = len_pow - (CNT_W+1)'(1);
  assign at_last   = (cnt == last_full[CNT_W-1:0]);

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // rst_done keeps in_ready low while reset is held and for no longer than one edge after.
  assign in_ready = rst_done && (state != PAD) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign pad_push = (state == PAD) && !fifo_full;
  assign push     = accept || pad_push;
  assign pop      = !fifo_empty && out_ready;

  always_comb begin
    state_nxt = state;
    push_sop  = 1'b0;
    push_err  = 2'b00;
    push_ch   = ch_q;
    push_inv  = inv_q;
    push_re   = '0;
    push_im   = '0;
    case (state)
      IDLE: begin
        push_sop = 1'b1;
        push_ch  = in_channel;
        push_inv = cfg_inverse;
        push_re  = in_real;
        push_im  = in_imag;
        if (accept && !at_last) state_nxt = FILL;
      end
      FILL: begin
        push_re     = in_real;
        push_im     = in_imag;
        push_err[0] = (in_channel != ch_q);
        if (accept && at_last) state_nxt = IDLE;
        else if (in_flush)     state_nxt = PAD;
      end
      PAD: begin
        push_err[1] = 1'b1;
        if (pad_push && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push_entry = {push_inv, push_im, push_re, push_sop, at_last, push_ch, push_err};

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      inv_q    <= 1'b0;
      ch_q     <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      state    <= state_nxt;
      if (push) cnt <= at_last ? '0 : cnt + CNT_W'(1);
      if (accept && (state == IDLE)) begin
        len_q <= cfg_len_clamped;
        inv_q <= cfg_inverse;
        ch_q  <= in_channel;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Zero the head when empty so stale storage never leaks onto the outputs.
  assign out_valid = !fifo_empty;
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign {out_data, out_sop, out_eop, out_channel, out_error} = head;

endmodule

// File: tb/tb_fft_frame_packer.sv
// tb/tb_fft_frame_packer.sv - directed self-checking bench for fft_frame_packer
module tb_fft_frame_packer;

  logic        clk;
  logic        reset_reset;
  logic        in_valid, in_ready;
  logic [13:0] in_real, in_imag;
  logic [1:0]  in_channel;
  logic        in_flush;
  logic [3:0]  cfg_len_log2;
  logic        cfg_inverse;
  logic        out_valid, out_ready;
  logic [28:0] out_data;
  logic        out_sop, out_eop;
  logic [1:0]  out_channel;
  logic [1:0]  out_error;

  int checks   = 0;
  int failures = 0;
  int accepted;
  int bad_marks;

  fft_frame_packer dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .in_channel   (in_channel),
    .in_flush     (in_flush),
    .cfg_len_log2 (cfg_len_log2),
    .cfg_inverse  (cfg_inverse),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_channel  (out_channel),
    .out_error    (out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] mk(input logic inv, input int im, input int re);
    return {inv, im[13:0], re[13:0]};
  endfunction

  task automatic exp_beat(input string tag, input logic [28:0] d, input logic sop,
                          input logic eop, input logic [1:0] ch, input logic [1:0] err);
    chk(tag, 64'({out_valid, out_data, out_sop, out_eop, out_channel, out_error}),
             64'({1'b1, d, sop, eop, ch, err}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_reset = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; in_channel = '0;
    in_flush = 1'b0; cfg_len_log2 = '0; cfg_inverse = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_outputs", 64'({out_valid, out_sop, out_eop, out_error, out_channel, out_data}), 64'(0));
    reset_reset = 1'b0;
    tick();
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    // basic frame; cfg changes mid-frame must not disturb it
    cfg_len_log2 = 4'd2; cfg_inverse = 1'b1; in_channel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_real = 14'(10 + i); in_imag = 14'(200 + i);
      if (i == 2) begin cfg_inverse = 1'b0; cfg_len_log2 = 4'd0; end
      chk("basic_in_ready", 64'(in_ready), 64'(1));
      tick();
      exp_beat("basic_beat", mk(1'b1, 200 + i, 10 + i), i == 0, i == 3, 2'd1, 2'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("basic_drained", 64'(out_valid), 64'(0));

    // flush after three beats of an 8-point frame
    cfg_len_log2 = 4'd3; cfg_inverse = 1'b1; in_channel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_real = 14'(i + 1); in_imag = 14'(i + 50);
      tick();
      exp_beat("flush_data_beat", mk(1'b1, i + 50, i + 1), i == 0, 1'b0, 2'd2, 2'd0);
    end
    in_valid = 1'b0; in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    chk("pad_entry_out_valid", 64'(out_valid), 64'(0));
    for (int k = 0; k < 5; k++) begin
      chk("pad_in_ready", 64'(in_ready), 64'(0));
      tick();
      exp_beat("pad_beat", mk(1'b1, 0, 0), 1'b0, k == 4, 2'd2, 2'b10);
    end
    chk("pad_done_in_ready", 64'(in_ready), 64'(1));
    tick();
    chk("pad_done_drained", 64'(out_valid), 64'(0));

    // flush together with the eop beat returns to IDLE without padding
    cfg_len_log2 = 4'd1; cfg_inverse = 1'b0; in_channel = 2'd3;
    in_valid = 1'b1; in_real = 14'd7; in_imag = 14'd0;
    tick();
    exp_beat("flush_eop_b0", mk(1'b0, 0, 7), 1'b1, 1'b0, 2'd3, 2'd0);
    in_real = 14'd8; in_flush = 1'b1;
    tick();
    exp_beat("flush_eop_b1", mk(1'b0, 0, 8), 1'b0, 1'b1, 2'd3, 2'd0);
    in_valid = 1'b0; in_flush = 1'b0;
    chk("flush_eop_in_ready", 64'(in_ready), 64'(1));
    tick();
    chk("flush_eop_no_pad", 64'(out_valid), 64'(0));

    // flush together with a mid-frame beat pads the rest
    cfg_len_log2 = 4'd2; in_channel = 2'd0;
    in_valid = 1'b1; in_real = 14'd21;
    tick();
    exp_beat("flush_mid_b0", mk(1'b0, 0, 21), 1'b1, 1'b0, 2'd0, 2'd0);
    in_real = 14'd22; in_flush = 1'b1;
    tick();
    exp_beat("flush_mid_b1", mk(1'b0, 0, 22), 1'b0, 1'b0, 2'd0, 2'd0);
    in_valid = 1'b0; in_flush = 1'b0;
    chk("flush_mid_in_ready", 64'(in_ready), 64'(0));
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_beat("flush_mid_pad", mk(1'b0, 0, 0), 1'b0, k == 1, 2'd0, 2'b10);
    end

    // channel mismatch on beat 2
    cfg_len_log2 = 4'd2; cfg_inverse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_real = 14'(40 + i); in_imag = 14'd5;
      in_channel = (i == 2) ? 2'd3 : 2'd0;
      tick();
      exp_beat("mismatch_beat", mk(1'b0, 5, 40 + i), i == 0, i == 3, 2'd0, (i == 2) ? 2'b01 : 2'b00);
    end
    in_valid = 1'b0;
    tick();

    // backpressure: 20 offered, 16 fit
    out_ready = 1'b0; cfg_len_log2 = 4'd10; in_channel = 2'd1; in_imag = 14'd0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_real = 14'(100 + accepted);
      if (in_ready) accepted++;
      tick();
    end
    chk("bp_accepted", 64'(accepted), 64'(16));
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    exp_beat("bp_head_held", mk(1'b0, 0, 100), 1'b1, 1'b0, 2'd1, 2'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_beat("bp_drain", mk(1'b0, 0, 100 + j), j == 0, 1'b0, 2'd1, 2'd0);
      tick();
    end
    chk("bp_drained", 64'(out_valid), 64'(0));

    // reset mid-frame (frame above is still open)
    reset_reset = 1'b1;
    #1;
    chk("midreset_in_ready", 64'(in_ready), 64'(0));
    chk("midreset_out_valid", 64'(out_valid), 64'(0));
    tick();
    reset_reset = 1'b0;
    tick();
    chk("midreset_recover", 64'(in_ready), 64'(1));

    // oversize length clamps to 1024 points; first beat after reset carries sop
    cfg_len_log2 = 4'd15; cfg_inverse = 1'b1; in_channel = 2'd2; in_imag = 14'd0;
    bad_marks = 0;
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_real = 14'(i);
      tick();
      if (i == 0)
        exp_beat("clamp_first", mk(1'b1, 0, 0), 1'b1, 1'b0, 2'd2, 2'd0);
      else if (i == 1023)
        exp_beat("clamp_last", mk(1'b1, 0, 1023), 1'b0, 1'b1, 2'd2, 2'd0);
      else if (out_sop || out_eop || !out_valid)
        bad_marks++;
    end
    chk("clamp_mid_marks", 64'(bad_marks), 64'(0));

    // length 1: every beat is sop+eop; flush ignored in IDLE
    cfg_len_log2 = 4'd0; in_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_channel = 2'(i); cfg_inverse = i[0]; in_real = 14'(300 + i);
      tick();
      exp_beat("len1_beat", mk(i[0], 0, 300 + i), 1'b1, 1'b1, 2'(i), 2'd0);
    end
    in_valid = 1'b0; in_flush = 1'b0;
    chk("len1_in_ready", 64'(in_ready), 64'(1));
    tick();
    chk("len1_drained", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
